// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared types, widths and address helper for the data-memory
//             arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        S_CPU      = 2'd0,
        S_IO_FORCE = 2'd1,
        S_IO_LOCK  = 2'd2
    } arb_state_t;

    // Byte address to word address, keeping only the decoded address bits.
    function automatic logic [c_DATA_W-1:0] word_addr(
        input logic [c_DATA_W-1:0] byte_addr,
        input int                  addr_bits
    );
        logic [c_DATA_W-1:0] v_mask;
        v_mask = (c_DATA_W'(1) << (addr_bits - 2)) - c_DATA_W'(1);
        return (byte_addr >> 2) & v_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_sat_counter
//  Brief    : Saturating up-counter with synchronous clear (clear wins).
//  Revision : 1.0  initial release
// ============================================================================
module arb_sat_counter #(
    parameter int MAX   = 4,
    parameter int WIDTH = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Brief    : Single-port data memory arbiter between the MEM stage and an
//             I/O master, with starvation forcing and bounded lock.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int IO_MAX_WAIT = 4,
    parameter int LOCK_MAX    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [c_DATA_W-1:0] cpu_addr,
    input  logic [c_DATA_W-1:0] cpu_wdata,
    output logic [c_DATA_W-1:0] cpu_rdata,
    output logic                cpu_stall,
    input  logic                io_req,
    input  logic                io_we,
    input  logic                io_lock,
    input  logic [c_DATA_W-1:0] io_addr,
    input  logic [c_DATA_W-1:0] io_wdata,
    output logic                io_gnt,
    output logic                io_rvalid,
    output logic [c_DATA_W-1:0] io_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [c_DATA_W-1:0] mem_addr,
    output logic [c_DATA_W-1:0] mem_wdata,
    input  logic [c_DATA_W-1:0] mem_rdata
);

    localparam int c_WCNT_W = (IO_MAX_WAIT < 1) ? 1 : $clog2(IO_MAX_WAIT + 1);
    localparam int c_LCNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX);
    localparam logic [c_WCNT_W-1:0] c_WAIT_MAX  = c_WCNT_W'(IO_MAX_WAIT);
    localparam logic [c_LCNT_W-1:0] c_LOCK_LAST = c_LCNT_W'(LOCK_MAX - 1);

    arb_state_t          r_state;
    logic                r_lock_blocked;
    logic                r_io_rvalid;
    logic [c_DATA_W-1:0] r_io_rdata;

    logic                w_cpu_req;
    logic                w_cpu_gnt;
    logic                w_io_gnt;
    logic                w_wcnt_inc;
    logic                w_wcnt_clr;
    logic                w_wait_reach;
    logic                w_lock_take;
    logic                w_lock_last;
    logic                w_in_lock;
    logic [c_WCNT_W-1:0] w_wcnt;
    logic [c_LCNT_W-1:0] w_lcnt;
    logic [c_DATA_W-1:0] w_sel_addr;

    assign w_cpu_req = cpu_read | cpu_write;

    always_comb begin
        w_cpu_gnt = 1'b0;
        w_io_gnt  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_CPU: begin
                    w_cpu_gnt = w_cpu_req;
                    w_io_gnt  = io_req & ~w_cpu_req;
                end
                default: begin
                    w_io_gnt = io_req;
                end
            endcase
        end
    end

    // Starvation counter; the edge it saturates on hands the next cycle to I/O.
    assign w_wcnt_inc   = io_req & ~w_io_gnt;
    assign w_wcnt_clr   = ~io_req | w_io_gnt;
    assign w_wait_reach = w_wcnt_inc && (w_wcnt >= (c_WAIT_MAX - 1'b1));

    arb_sat_counter #(
        .MAX   (IO_MAX_WAIT),
        .WIDTH (c_WCNT_W)
    ) u_wcnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_wcnt_clr),
        .i_inc   (w_wcnt_inc),
        .o_count (w_wcnt)
    );

    // Lock counter idles at zero outside the lock, so it starts fresh on entry.
    assign w_in_lock   = (r_state == S_IO_LOCK);
    assign w_lock_last = (w_lcnt == c_LOCK_LAST);
    assign w_lock_take = w_io_gnt & io_lock & ~r_lock_blocked;

    arb_sat_counter #(
        .MAX   (LOCK_MAX - 1),
        .WIDTH (c_LCNT_W)
    ) u_lcnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (~w_in_lock),
        .i_inc   (w_in_lock),
        .o_count (w_lcnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_CPU;
            r_lock_blocked <= 1'b0;
            r_io_rvalid    <= 1'b0;
            r_io_rdata     <= '0;
        end else begin
            r_io_rvalid <= w_io_gnt & ~io_we;
            if (w_io_gnt && !io_we) begin
                r_io_rdata <= mem_rdata;
            end

            case (r_state)
                S_CPU: begin
                    if (w_lock_take) begin
                        r_state <= S_IO_LOCK;
                    end else if (w_wait_reach) begin
                        r_state <= S_IO_FORCE;
                    end
                end
                S_IO_FORCE: begin
                    r_state <= w_lock_take ? S_IO_LOCK : S_CPU;
                end
                S_IO_LOCK: begin
                    if (!io_lock || w_lock_last) begin
                        r_state <= S_CPU;
                    end
                end
                default: begin
                    r_state <= S_CPU;
                end
            endcase

            // A timed-out lock stays refused until io_lock is seen low.
            if (!io_lock) begin
                r_lock_blocked <= 1'b0;
            end else if (w_in_lock && w_lock_last) begin
                r_lock_blocked <= 1'b1;
            end
        end
    end

    assign w_sel_addr = w_io_gnt ? io_addr : cpu_addr;
    assign mem_addr   = word_addr(w_sel_addr, ADDR_BITS);
    assign mem_wdata  = w_io_gnt ? io_wdata : cpu_wdata;
    assign mem_read   = (w_cpu_gnt & cpu_read)  | (w_io_gnt & ~io_we);
    assign mem_write  = (w_cpu_gnt & cpu_write) | (w_io_gnt & io_we);

    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = w_cpu_req & ~w_cpu_gnt & ~reset;
    assign io_gnt     = w_io_gnt;
    assign io_rvalid  = r_io_rvalid;
    assign io_rdata   = r_io_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Brief    : Directed and randomized checks of data_mem_arbiter against a
//             cycle-level ownership model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int ADDR_BITS   = 12;
    localparam int IO_MAX_WAIT = 4;
    localparam int LOCK_MAX    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        io_req, io_we, io_lock;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_gnt, io_rvalid;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_BITS   (ADDR_BITS),
        .IO_MAX_WAIT (IO_MAX_WAIT),
        .LOCK_MAX    (LOCK_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_lock   (io_lock),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_gnt    (io_gnt),
        .io_rvalid (io_rvalid),
        .io_rdata  (io_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Physical memory seen by the DUT.
    logic [31:0] phys_mem [1024];
    assign mem_rdata = phys_mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_write) phys_mem[mem_addr[9:0]] <= mem_wdata;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns each cycle, expressed as wait/lock budgets.
    logic [31:0] ref_mem [1024];
    int          waited;
    int          lock_left;
    bit          force_io;
    bit          relock_barred;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    bit          e_cg, e_ig, e_stall;

    function automatic int unsigned wa(input logic [31:0] a);
        return (a % (32'd1 << ADDR_BITS)) / 4;
    endfunction

    task automatic model_comb();
        bit creq;
        creq = cpu_read | cpu_write;
        if (reset) begin
            e_cg = 0; e_ig = 0;
        end else if (lock_left > 0 || force_io) begin
            e_cg = 0; e_ig = io_req;
        end else begin
            e_cg = creq; e_ig = io_req && !creq;
        end
        e_stall = creq && !e_cg && !reset;
    endtask

    task automatic model_seq();
        if (reset) begin
            waited = 0; lock_left = 0; force_io = 0; relock_barred = 0;
            e_rvalid = 1'b0; e_rdata = '0;
            return;
        end
        if (e_ig && !io_we) begin
            e_rvalid = 1'b1;
            e_rdata  = ref_mem[wa(io_addr)];
        end else begin
            e_rvalid = 1'b0;
        end
        if (e_cg && cpu_write) ref_mem[wa(cpu_addr)] = cpu_wdata;
        if (e_ig && io_we)     ref_mem[wa(io_addr)]  = io_wdata;

        waited = (io_req && !e_ig) ? ((waited + 1 > IO_MAX_WAIT) ? IO_MAX_WAIT : waited + 1) : 0;

        if (lock_left > 0) begin
            lock_left--;
            if (!io_lock) lock_left = 0;
            else if (lock_left == 0) relock_barred = 1;
        end else if (e_ig && io_lock && !relock_barred) begin
            lock_left = LOCK_MAX;
            force_io  = 0;
        end else if (force_io) begin
            force_io = 0;
        end else if (waited == IO_MAX_WAIT) begin
            force_io = 1;
        end
        if (!io_lock) relock_barred = 0;
    endtask

    task automatic step();
        logic [31:0] ga;
        bit          e_rd, e_wr;
        @(negedge clk);
        model_comb();
        e_rd = (e_cg && cpu_read)  || (e_ig && !io_we);
        e_wr = (e_cg && cpu_write) || (e_ig && io_we);
        ga   = e_ig ? io_addr : cpu_addr;
        check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        check("io_gnt",    32'(io_gnt),    32'(e_ig));
        check("mem_read",  32'(mem_read),  32'(e_rd));
        check("mem_write", 32'(mem_write), 32'(e_wr));
        if (e_rd || e_wr) check("mem_addr", mem_addr, 32'(wa(ga)));
        if (e_wr) check("mem_wdata", mem_wdata, e_ig ? io_wdata : cpu_wdata);
        if (e_cg && cpu_read) check("cpu_rdata", cpu_rdata, ref_mem[wa(cpu_addr)]);
        check("io_rvalid", 32'(io_rvalid), 32'(e_rvalid));
        check("io_rdata",  io_rdata, e_rdata);
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic set_cpu(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        cpu_read = r; cpu_write = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_io(input bit rq, input bit we, input bit lk, input logic [31:0] a, input logic [31:0] d);
        io_req = rq; io_we = we; io_lock = lk; io_addr = a; io_wdata = d;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    task automatic randomize_inputs();
        int sel;
        reset = ($urandom_range(0, 299) == 0);
        if (!(io_req && !e_ig && !reset)) begin
            if ($urandom_range(0, 5) == 0) io_lock = ~io_lock;
            io_req   = ($urandom_range(0, 2) != 0);
            io_we    = $urandom_range(0, 1) != 0;
            io_addr  = rand_addr();
            io_wdata = $urandom;
        end
        if (!e_stall) begin
            sel = $urandom_range(0, 3);
            set_cpu(sel == 1 || sel == 2, sel == 3, rand_addr(), $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        waited = 0; lock_left = 0; force_io = 0; relock_barred = 0;
        e_rvalid = 1'b0; e_rdata = '0; e_cg = 0; e_ig = 0; e_stall = 0;

        // Requests active during reset must be masked.
        reset = 1'b1;
        set_cpu(0, 1, 32'h20, 32'h12345678);
        set_io(1, 1, 0, 32'h24, 32'h0BADF00D);
        @(posedge clk); #1;
        step();
        step();
        reset = 1'b0;
        set_cpu(0, 0, 0, 0);
        set_io(0, 0, 0, 0, 0);
        step();

        // CPU only
        set_cpu(0, 1, 32'h010, 32'hDEADBEEF); step();
        set_cpu(1, 0, 32'h010, 32'h0);        step();
        set_cpu(1, 0, 32'h020, 32'h0);        step();
        set_cpu(0, 0, 0, 0);

        // I/O read on an idle CPU
        set_io(1, 0, 0, 32'h010, 0); step();
        set_io(0, 0, 0, 0, 0);       step();

        // Starvation under continuous CPU reads
        set_cpu(1, 0, 32'h010, 0);
        set_io(1, 0, 0, 32'h010, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (io_req && e_ig) io_req = 1'b0;
        end
        set_cpu(0, 0, 0, 0);

        // Short lock held three cycles
        set_io(1, 1, 1, 32'h080, 32'hA5A5_0001); step();
        set_cpu(1, 0, 32'h080, 0);
        set_io(1, 0, 1, 32'h080, 0); step();
        set_io(0, 0, 1, 32'h080, 0); step();
        set_io(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        set_cpu(0, 0, 0, 0);

        // Long lock: forced release, no relock while io_lock stays high
        set_io(1, 1, 1, 32'h090, 32'hA5A5_0002); step();
        set_cpu(1, 0, 32'h090, 0);
        for (int i = 0; i < 19; i++) begin
            if (!(io_req && !e_ig)) begin
                io_req   = $urandom_range(0, 1) != 0;
                io_we    = $urandom_range(0, 1) != 0;
                io_addr  = 32'h090;
                io_wdata = $urandom;
            end
            step();
        end
        set_io(0, 0, 0, 0, 0);
        set_cpu(0, 0, 0, 0);
        step();
        step();

        // Reset in the third lock cycle
        set_io(1, 0, 1, 32'h010, 0); step();
        set_cpu(1, 0, 32'h010, 0);
        set_io(0, 0, 1, 0, 0);       step();
        step();
        reset = 1'b1;
        set_io(1, 1, 1, 32'h100, 32'hCAFEF00D); step();
        reset = 1'b0;
        set_io(0, 0, 0, 0, 0);
        step();
        set_cpu(1, 0, 32'h100, 0); step();

        // Randomized traffic
        set_cpu(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
